// File: rtl/alarm_time_ctrl_pkg.sv
// alarm_time_ctrl_pkg: shared widths, time limits and sequencer state encoding
//   HOURS_PER_DAY / MINS_PER_HOUR : wrap points for the alarm registers
//   HOUR_W / MIN_W / SEC_W        : time field widths
//   alm_state_e                   : 2-bit ring sequencer state
package alarm_pkg;
    localparam int HOURS_PER_DAY = 24;
    localparam int MINS_PER_HOUR = 60;
    localparam int HOUR_W = 5;
    localparam int MIN_W = 6;
    localparam int SEC_W = 6;
    typedef enum logic [1:0] {IDLE = 2'd0, RING = 2'd1, SNOOZE = 2'd2} alm_state_e;
endpackage

// File: rtl/alarm_time_ctrl_if.sv
// alarm_time_ctrl_if: switches, mode indicators, running time and alarm outputs
//   master : drives switches, mode, tick and time; observes alarm outputs
//   slave  : the alarm controller
interface alarm_time_ctrl_if;
    import alarm_pkg::*;
    logic              SW_F1;
    logic              SW_F2;
    logic              ALM_ONOFF;
    logic              ALM_HOUR;
    logic              ALM_MIN;
    logic              TICK_1HZ;
    logic [HOUR_W-1:0] CUR_HOUR;
    logic [MIN_W-1:0]  CUR_MIN;
    logic [SEC_W-1:0]  CUR_SEC;
    logic [HOUR_W-1:0] ALM_HOUR_VAL;
    logic [MIN_W-1:0]  ALM_MIN_VAL;
    logic              ALM_EN;
    logic              RINGING;
    logic              SNOOZING;
    logic              BUZZ;
    modport master (
        output SW_F1, SW_F2, ALM_ONOFF, ALM_HOUR, ALM_MIN, TICK_1HZ, CUR_HOUR, CUR_MIN, CUR_SEC,
        input  ALM_HOUR_VAL, ALM_MIN_VAL, ALM_EN, RINGING, SNOOZING, BUZZ
    );
    modport slave (
        input  SW_F1, SW_F2, ALM_ONOFF, ALM_HOUR, ALM_MIN, TICK_1HZ, CUR_HOUR, CUR_MIN, CUR_SEC,
        output ALM_HOUR_VAL, ALM_MIN_VAL, ALM_EN, RINGING, SNOOZING, BUZZ
    );
endinterface

// File: rtl/alarm_time_ctrl_sw_edge_det.sv
// sw_edge_det: registered one-cycle pulse on each rising edge of a debounced switch
//   CLK, RST : clock, synchronous active-high reset
//   level    : switch level
//   pulse    : high for one cycle, the cycle after the rising edge was sampled
module sw_edge_det (
    input  logic CLK,
    input  logic RST,
    input  logic level,
    output logic pulse
);
    logic prev;
    always_ff @(posedge CLK) begin
        if (RST) begin
            prev  <= 1'b0;
            pulse <= 1'b0;
        end else begin
            prev  <= level;
            pulse <= level & ~prev;
        end
    end
endmodule

// File: rtl/alarm_time_ctrl.sv
// alarm_time_ctrl: alarm registers, F2 edits, time match and RING/SNOOZE buzzer sequencer
//   CLK, RST : clock, synchronous active-high reset
//   bus      : switches, mode indicators, 1 Hz tick, running time in; alarm value, enable,
//              ringing/snoozing status and buzzer out (all registered)
module alarm_time_ctrl
    import alarm_pkg::*;
#(
    parameter int RING_SECS   = 60,
    parameter int SNOOZE_SECS = 300,
    parameter int MAX_SNOOZE  = 3
) (
    input logic CLK,
    input logic RST,
    alarm_time_ctrl_if.slave bus
);
    localparam int CNT_W = $clog2((RING_SECS > SNOOZE_SECS ? RING_SECS : SNOOZE_SECS) + 1);
    localparam int SNZ_W = MAX_SNOOZE > 0 ? $clog2(MAX_SNOOZE + 1) : 1;

    alm_state_e        state, state_nx;
    logic [CNT_W-1:0]  cnt, cnt_nx;
    logic [SNZ_W-1:0]  snz, snz_nx;
    logic              phase, phase_nx;
    logic [HOUR_W-1:0] hour;
    logic [MIN_W-1:0]  min;
    logic              en, ringing, snoozing, buzz;
    logic              f1_p, f2_p, mode_valid, edit, match;

    sw_edge_det u_f1 (.CLK(CLK), .RST(RST), .level(bus.SW_F1), .pulse(f1_p));
    sw_edge_det u_f2 (.CLK(CLK), .RST(RST), .level(bus.SW_F2), .pulse(f2_p));

    assign mode_valid = $onehot({bus.ALM_HOUR, bus.ALM_MIN, bus.ALM_ONOFF});
    assign edit       = f2_p & mode_valid;
    // compares against the pre-edit registers, so a same-cycle disable still lets this match through
    assign match = en & bus.TICK_1HZ & (bus.CUR_SEC == '0) & (bus.CUR_HOUR == hour) & (bus.CUR_MIN == min);

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        snz_nx   = snz;
        phase_nx = phase;
        case (state)
            IDLE: if (match) begin
                state_nx = RING;
                cnt_nx   = '0;
                snz_nx   = '0;
                phase_nx = 1'b1;
            end
            RING: if (f1_p || !en) begin
                state_nx = IDLE;
            end else if (f2_p && !mode_valid && snz < SNZ_W'(MAX_SNOOZE)) begin
                state_nx = SNOOZE;
                snz_nx   = snz + 1'b1;
                cnt_nx   = '0;
            end else if (bus.TICK_1HZ) begin
                cnt_nx   = cnt + 1'b1;
                phase_nx = ~phase;
                if (cnt_nx == CNT_W'(RING_SECS)) state_nx = IDLE;
            end
            SNOOZE: if (f1_p || !en) begin
                state_nx = IDLE;
            end else if (bus.TICK_1HZ) begin
                cnt_nx = cnt + 1'b1;
                if (cnt_nx == CNT_W'(SNOOZE_SECS)) begin
                    state_nx = RING;
                    cnt_nx   = '0;
                    phase_nx = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            cnt      <= '0;
            snz      <= '0;
            phase    <= 1'b0;
            hour     <= '0;
            min      <= '0;
            en       <= 1'b0;
            ringing  <= 1'b0;
            snoozing <= 1'b0;
            buzz     <= 1'b0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            snz      <= snz_nx;
            phase    <= phase_nx;
            if (edit && bus.ALM_HOUR) hour <= (hour == HOUR_W'(HOURS_PER_DAY - 1)) ? '0 : hour + 1'b1;
            if (edit && bus.ALM_MIN) min <= (min == MIN_W'(MINS_PER_HOUR - 1)) ? '0 : min + 1'b1;
            if (edit && bus.ALM_ONOFF) en <= ~en;
            ringing  <= state_nx == RING;
            snoozing <= state_nx == SNOOZE;
            buzz     <= (state_nx == RING) & phase_nx;
        end
    end

    assign bus.ALM_HOUR_VAL = hour;
    assign bus.ALM_MIN_VAL  = min;
    assign bus.ALM_EN       = en;
    assign bus.RINGING      = ringing;
    assign bus.SNOOZING     = snoozing;
    assign bus.BUZZ         = buzz;
endmodule

// File: tb/tb_alarm_time_ctrl.sv
// tb_alarm_time_ctrl: directed and randomized checks of alarm_time_ctrl against a behavioural model
module tb_alarm_time_ctrl;
    localparam int RS = 60, SS = 300, MS = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_run = 0, n_fail = 0;

    alarm_time_ctrl_if bus ();
    alarm_time_ctrl #(.RING_SECS(RS), .SNOOZE_SECS(SS), .MAX_SNOOZE(MS)) dut (.CLK(clk), .RST(rst), .bus(bus));

    always #5 clk = ~clk;

    // Model: alarm time as plain integers, status as flags, "elapsed" seconds in the current phase.
    // A switch press acts one edge after its rising edge is sampled.
    int m_hour, m_min, m_el, m_snz;
    bit m_en, m_ring, m_snooze;
    bit f1_h0, f1_h1, f2_h0, f2_h1;
    bit p1, p2, mv, mt, en0;

    always @(posedge clk) begin
        if (rst) begin
            m_hour = 0; m_min = 0; m_en = 0; m_ring = 0; m_snooze = 0; m_el = 0; m_snz = 0;
            f1_h0 = 0; f1_h1 = 0; f2_h0 = 0; f2_h1 = 0;
        end else begin
            p1 = f1_h0 && !f1_h1;
            p2 = f2_h0 && !f2_h1;
            f1_h1 = f1_h0; f1_h0 = bus.SW_F1;
            f2_h1 = f2_h0; f2_h0 = bus.SW_F2;
            mv = (int'(bus.ALM_HOUR) + int'(bus.ALM_MIN) + int'(bus.ALM_ONOFF)) == 1;
            mt = m_en && bus.TICK_1HZ && bus.CUR_SEC == 0 && int'(bus.CUR_HOUR) == m_hour && int'(bus.CUR_MIN) == m_min;
            en0 = m_en;
            if (p2 && mv) begin
                if (bus.ALM_HOUR) m_hour = (m_hour + 1) % 24;
                if (bus.ALM_MIN) m_min = (m_min + 1) % 60;
                if (bus.ALM_ONOFF) m_en = !m_en;
            end
            if (m_ring) begin
                if (p1 || !en0) m_ring = 0;
                else if (p2 && !mv && m_snz < MS) begin
                    m_ring = 0; m_snooze = 1; m_snz++; m_el = 0;
                end else if (bus.TICK_1HZ) begin
                    m_el++;
                    if (m_el == RS) m_ring = 0;
                end
            end else if (m_snooze) begin
                if (p1 || !en0) m_snooze = 0;
                else if (bus.TICK_1HZ) begin
                    m_el++;
                    if (m_el == SS) begin
                        m_snooze = 0; m_ring = 1; m_el = 0;
                    end
                end
            end else if (mt) begin
                m_ring = 1; m_el = 0; m_snz = 0;
            end
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc;
        @(posedge clk);
        @(negedge clk);
        check("hour", int'(bus.ALM_HOUR_VAL), m_hour);
        check("min", int'(bus.ALM_MIN_VAL), m_min);
        check("en", int'(bus.ALM_EN), int'(m_en));
        check("ringing", int'(bus.RINGING), int'(m_ring));
        check("snoozing", int'(bus.SNOOZING), int'(m_snooze));
        check("buzz", int'(bus.BUZZ), int'(m_ring && m_el % 2 == 0));
    endtask

    task automatic press2;
        bus.SW_F2 = 1'b1; cyc();
        bus.SW_F2 = 1'b0; cyc(); cyc();
    endtask

    task automatic press1;
        bus.SW_F1 = 1'b1; cyc();
        bus.SW_F1 = 1'b0; cyc(); cyc();
    endtask

    task automatic tk(input int n);
        repeat (n) begin
            bus.TICK_1HZ = 1'b1; cyc();
            bus.TICK_1HZ = 1'b0; cyc();
        end
    endtask

    task automatic trig(input int h, input int m);
        bus.CUR_HOUR = 5'(h); bus.CUR_MIN = 6'(m); bus.CUR_SEC = '0;
        bus.TICK_1HZ = 1'b1; cyc();
        bus.TICK_1HZ = 1'b0; bus.CUR_SEC = 6'd1;
    endtask

    initial begin
        bus.SW_F1 = 0; bus.SW_F2 = 0; bus.ALM_ONOFF = 0; bus.ALM_HOUR = 0; bus.ALM_MIN = 0;
        bus.TICK_1HZ = 0; bus.CUR_HOUR = 5'd12; bus.CUR_MIN = 6'd0; bus.CUR_SEC = 6'd5;
        rst = 1; cyc(); cyc(); rst = 0;
        check("rst_ringing", int'(bus.RINGING), 0);
        check("rst_hour", int'(bus.ALM_HOUR_VAL), 0);
        // hour wraps after 23, minute after 59
        bus.ALM_HOUR = 1; repeat (25) press2(); bus.ALM_HOUR = 0;
        check("hour_wrap", int'(bus.ALM_HOUR_VAL), 1);
        bus.ALM_MIN = 1; repeat (61) press2(); bus.ALM_MIN = 0;
        check("min_wrap", int'(bus.ALM_MIN_VAL), 1);
        check("min_no_carry", int'(bus.ALM_HOUR_VAL), 1);
        // invalid mode, then a held switch
        bus.ALM_HOUR = 1; bus.ALM_MIN = 1; press2(); bus.ALM_HOUR = 0;
        check("two_modes_hour", int'(bus.ALM_HOUR_VAL), 1);
        check("two_modes_min", int'(bus.ALM_MIN_VAL), 1);
        bus.SW_F2 = 1; repeat (100) cyc(); bus.SW_F2 = 0; cyc(); bus.ALM_MIN = 0;
        check("held_once", int'(bus.ALM_MIN_VAL), 2);
        // set 07:30 and arm
        bus.ALM_HOUR = 1; repeat (6) press2(); bus.ALM_HOUR = 0;
        bus.ALM_MIN = 1; repeat (28) press2(); bus.ALM_MIN = 0;
        bus.ALM_ONOFF = 1; press2(); bus.ALM_ONOFF = 0;
        check("armed", int'(bus.ALM_EN), 1);
        check("set_hour", int'(bus.ALM_HOUR_VAL), 7);
        check("set_min", int'(bus.ALM_MIN_VAL), 30);
        // ring then auto-stop after 60 s
        trig(7, 30);
        check("ring_start", int'(bus.RINGING), 1);
        check("buzz_start", int'(bus.BUZZ), 1);
        tk(59);
        check("ring_59", int'(bus.RINGING), 1);
        tk(1);
        check("ring_timeout", int'(bus.RINGING), 0);
        check("buzz_timeout", int'(bus.BUZZ), 0);
        // snooze three times, fourth press ignored
        cyc(); trig(7, 30);
        repeat (MS) begin
            press2();
            check("snoozing", int'(bus.SNOOZING), 1);
            tk(SS);
            check("re_ring", int'(bus.RINGING), 1);
        end
        press2();
        check("snooze_limit_ring", int'(bus.RINGING), 1);
        check("snooze_limit_snz", int'(bus.SNOOZING), 0);
        press1();
        check("dismiss", int'(bus.RINGING), 0);
        // dismiss coinciding with the final tick
        trig(7, 30); tk(59);
        bus.SW_F1 = 1; cyc();
        bus.SW_F1 = 0; bus.TICK_1HZ = 1; cyc();
        bus.TICK_1HZ = 0;
        check("f1_and_timeout", int'(bus.RINGING), 0);
        cyc();
        // disarm while snoozing
        trig(7, 30); press2();
        check("snooze2", int'(bus.SNOOZING), 1);
        bus.ALM_ONOFF = 1; press2(); bus.ALM_ONOFF = 0;
        check("disarm_snz", int'(bus.SNOOZING), 0);
        check("disarm_en", int'(bus.ALM_EN), 0);
        // reset mid-ring
        bus.ALM_ONOFF = 1; press2(); bus.ALM_ONOFF = 0;
        trig(7, 30);
        check("ring_pre_rst", int'(bus.RINGING), 1);
        rst = 1; cyc(); rst = 0;
        check("rst_ring", int'(bus.RINGING), 0);
        check("rst_buzz", int'(bus.BUZZ), 0);
        check("rst_en", int'(bus.ALM_EN), 0);
        check("rst_min", int'(bus.ALM_MIN_VAL), 0);
        // match while disarmed
        trig(0, 0);
        check("disarmed_match", int'(bus.RINGING), 0);
        // match on the same edge as disarm: one RING cycle
        bus.ALM_ONOFF = 1; press2();
        bus.SW_F2 = 1; cyc();
        bus.SW_F2 = 0; bus.TICK_1HZ = 1; bus.CUR_SEC = 0; cyc();
        bus.TICK_1HZ = 0; bus.CUR_SEC = 1; bus.ALM_ONOFF = 0;
        check("match_disarm_ring", int'(bus.RINGING), 1);
        check("match_disarm_en", int'(bus.ALM_EN), 0);
        cyc();
        check("match_disarm_idle", int'(bus.RINGING), 0);
        // randomized phase
        for (int i = 0; i < 4000; i++) begin
            rst = $urandom_range(0, 399) == 0;
            if ($urandom_range(0, 5) == 0) bus.SW_F1 = ~bus.SW_F1 & ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 3) == 0) bus.SW_F2 = ~bus.SW_F2;
            if ($urandom_range(0, 15) == 0) begin
                case ($urandom_range(0, 7))
                    0: {bus.ALM_HOUR, bus.ALM_MIN, bus.ALM_ONOFF} = 3'b100;
                    1: {bus.ALM_HOUR, bus.ALM_MIN, bus.ALM_ONOFF} = 3'b010;
                    2, 3: {bus.ALM_HOUR, bus.ALM_MIN, bus.ALM_ONOFF} = 3'b001;
                    4: {bus.ALM_HOUR, bus.ALM_MIN, bus.ALM_ONOFF} = 3'($urandom_range(0, 7));
                    default: {bus.ALM_HOUR, bus.ALM_MIN, bus.ALM_ONOFF} = 3'b000;
                endcase
            end
            bus.TICK_1HZ = $urandom_range(0, 2) == 0;
            if ($urandom_range(0, 1) == 1) begin
                bus.CUR_HOUR = 5'(m_hour); bus.CUR_MIN = 6'(m_min);
            end else begin
                bus.CUR_HOUR = 5'($urandom_range(0, 23)); bus.CUR_MIN = 6'($urandom_range(0, 59));
            end
            bus.CUR_SEC = ($urandom_range(0, 1) == 1) ? 6'd0 : 6'($urandom_range(0, 59));
            cyc();
        end
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/alarm_time_ctrl.md
Name: alarm_time_ctrl

Overview:
Alarm datapath and ring sequencer for the digital clock. It consumes the one-hot alarm setting-mode indicators (ALM_HOUR/ALM_MIN/ALM_ONOFF) from the alarm mode FSM, holds the alarm hour/minute/enable registers, and edits them on SW_F2 presses. It compares the alarm against the running time and drives the buzzer through a RING/SNOOZE state machine with timeout and dismiss.

Parameters:
RING_SECS, 60, seconds of ringing before auto-stop to IDLE
SNOOZE_SECS, 300, seconds spent in SNOOZE before re-ringing
MAX_SNOOZE, 3, snoozes allowed per alarm event; further SW_F2 presses in RING are ignored

Ports:
CLK  input  1  system clock
RST  input  1  reset; synchronous to CLK, active-high
SW_F1  input  1  dismiss switch, level, already debounced
SW_F2  input  1  increment/snooze switch, level, already debounced
ALM_ONOFF  input  1  mode indicator: edit enable
ALM_HOUR  input  1  mode indicator: edit hour
ALM_MIN  input  1  mode indicator: edit minute
TICK_1HZ  input  1  one-CLK-wide pulse, once per second
CUR_HOUR  input  5  current hour, 0..23
CUR_MIN  input  6  current minute, 0..59
CUR_SEC  input  6  current second, 0..59
ALM_HOUR_VAL  output  5  stored alarm hour
ALM_MIN_VAL  output  6  stored alarm minute
ALM_EN  output  1  alarm armed
RINGING  output  1  high in RING state
SNOOZING  output  1  high in SNOOZE state
BUZZ  output  1  buzzer drive

Behaviour:
- Reset (RST high at a CLK edge): ALM_HOUR_VAL=0, ALM_MIN_VAL=0, ALM_EN=0, state IDLE, RINGING=0, SNOOZING=0, BUZZ=0, second counter=0, snooze count=0, edge-detector history=0. RST takes priority over all other inputs, including mid-RING and mid-SNOOZE.
- Edge detect: press = switch high now and low on the previous CLK. Exactly one press per rising edge. A held switch produces no repeats.
- Mode valid: exactly one of ALM_HOUR/ALM_MIN/ALM_ONOFF is high. With zero or more than one high, no edit occurs.
- Edits take effect on the CLK edge after the F2 press is sampled (1-cycle latency):
  - ALM_HOUR mode: hour +1, 23 wraps to 0.
  - ALM_MIN mode: minute +1, 59 wraps to 0, with no carry into hour.
  - ALM_ONOFF mode: ALM_EN toggles.
- Match: ALM_EN=1, TICK_1HZ=1, CUR_SEC=0, CUR_HOUR=ALM_HOUR_VAL, CUR_MIN=ALM_MIN_VAL. The comparison uses register values before any same-cycle edit.
- States: IDLE, RING, SNOOZE. Encoding is 2 bits and lives in the package.
- IDLE -> RING on match. Clears the second counter and snooze count.
- RING:
  - Second counter increments on each TICK_1HZ.
  - Counter reaching RING_SECS -> IDLE.
  - F1 press -> IDLE (dismiss).
  - F2 press with no valid mode and snooze count < MAX_SNOOZE -> SNOOZE; snooze count +1; counter cleared.
  - F2 press with a valid mode edits only and does not snooze.
- SNOOZE:
  - Counter increments on TICK_1HZ.
  - Counter reaching SNOOZE_SECS -> RING, counter cleared.
  - F1 press -> IDLE.
  - F2 is ignored except for edits.
- ALM_EN going 0 while in RING or SNOOZE -> IDLE on the next edge.
- Simultaneous events:
  - F1 dismiss beats a timeout on the same cycle.
  - A match while in RING/SNOOZE is ignored.
  - A match on the same cycle as ALM_EN toggling off still enters RING for one cycle, then IDLE.
- RINGING and SNOOZING are registered state decodes.
- BUZZ: in RING, a phase bit toggles on each TICK_1HZ; BUZZ = phase (1 s on / 1 s off). On entry to RING, phase=1 so BUZZ is high in the first RING cycle. BUZZ is 0 outside RING.
- All outputs are registered.
- Second counter width is clog2(max(RING_SECS, SNOOZE_SECS)+1).

Decomposition:
- Package alarm_pkg:
  - HOURS_PER_DAY=24, MINS_PER_HOUR=60
  - field widths 5/6/6
  - state enum IDLE=0, RING=1, SNOOZE=2
- Sub-module sw_edge_det (CLK, RST, level in, one-cycle pulse out). Instantiated twice, for F1 and F2.

Test Plan:
- Reset, then ALM_HOUR=1 with 25 F2 presses -> ALM_HOUR_VAL ends at 1 (wraps after 23). ALM_MIN=1 with 61 presses -> ALM_MIN_VAL=1.
- ALM_HOUR and ALM_MIN both high with an F2 press -> no register change. F2 held high for 100 cycles -> exactly one increment.
- Set alarm 07:30 and ALM_EN=1. Drive CUR=07:30:00 with TICK_1HZ -> RINGING=1 next edge, BUZZ=1. After 60 ticks with no input -> IDLE, BUZZ=0.
- In RING, F2 press with no mode -> SNOOZING=1. After 300 ticks -> RINGING=1. Repeat until 3 snoozes; the 4th F2 press stays in RING.
- In RING, F1 press on the same cycle as the 60th tick -> IDLE. In SNOOZE, toggling ALM_EN via ALM_ONOFF+F2 -> IDLE, ALM_EN=0.
- Assert RST mid-RING -> all outputs 0 next edge. Match with ALM_EN=0 -> stays IDLE.
